// File: rtl/lu_row_mem.sv
// Row store serving the lu engine: 1-cycle row reads, write-backs, and L/U result banks,
// with host load/readback ports. Define LU_ROWMEM_ERR_EN to add the sticky err_o output.
module lu_row_mem #(
    parameter  int SIZE  = 16,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(SIZE),
    localparam int RW    = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          host_wr_valid_i,
    output logic          host_wr_ready_o,
    input  logic [AW-1:0] host_wr_addr_i,
    input  logic [RW-1:0] host_wr_row_i,
    input  logic          host_go_i,
    input  logic          host_rd_valid_i,
    output logic          host_rd_ready_o,
    input  logic [1:0]    host_rd_sel_i,
    input  logic [AW-1:0] host_rd_addr_i,
    output logic          host_rd_data_valid_o,
    output logic [RW-1:0] host_rd_data_o,
    output logic          start_o,
    output logic          done_o,
    input  logic [AW-1:0] mat_row_read_addr_i,
    input  logic          mat_row_read_addr_valid_i,
    output logic [RW-1:0] mat_row_o,
    output logic          mat_row_valid_o,
    output logic [AW-1:0] mat_row_read_addr_o,
    input  logic [RW-1:0] mat_row_wb_i,
    input  logic          mat_row_wb_valid_i,
    input  logic [AW-1:0] mat_row_write_addr_i,
    output logic          mat_row_out_ready_o,
    input  logic [RW-1:0] l_col_i,
    input  logic [RW-1:0] u_row_i,
    input  logic [AW-1:0] result_addr_i,
    input  logic          result_valid_i,
    output logic          result_out_ready_o,
    output logic [1:0]    state_o
`ifdef LU_ROWMEM_ERR_EN
    ,
    output logic          err_o
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [SIZE-1:0] r_load_bm;
    logic [SIZE-1:0] r_res_bm;
    logic [SIZE-1:0] w_res_bm_next;
    logic [RW-1:0]   r_mat [SIZE];
    logic [RW-1:0]   r_l   [SIZE];
    logic [RW-1:0]   r_u   [SIZE];
    logic [RW-1:0]   r_mat_row;
    logic            r_mat_row_valid;
    logic [AW-1:0]   r_mat_rd_addr;
    logic [RW-1:0]   r_hrd_data;
    logic            r_hrd_valid;

    logic w_load_full;
    logic w_go_ok;
    logic w_host_wr;
    logic w_host_rd;
    logic w_wb;
    logic w_res_acc;
    logic w_clear;

    // Every handshake transfers on a cycle where valid && ready are both high; the ready
    // side never depends on valid, so a requester may hold valid until it sees ready.
    assign w_load_full = &r_load_bm;
    assign w_go_ok     = host_go_i && w_load_full;
    assign w_host_wr   = host_wr_valid_i && host_wr_ready_o;
    assign w_host_rd   = host_rd_valid_i && host_rd_ready_o;
    assign w_wb        = mat_row_wb_valid_i && mat_row_out_ready_o;
    assign w_res_acc   = result_valid_i && result_out_ready_o;
    assign w_clear     = (r_state == ST_DONE) && host_go_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_res_bm_next = r_res_bm;
        if (w_res_acc) w_res_bm_next[result_addr_i] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go_ok)        w_state_next = ST_RUN;
                else if (w_host_wr) w_state_next = ST_LOAD;
            end
            ST_LOAD: if (w_go_ok) w_state_next = ST_RUN;
            // Looks at the post-accept bitmap so the final result lands in DONE next cycle.
            ST_RUN:  if (&w_res_bm_next) w_state_next = ST_DONE;
            ST_DONE: if (host_go_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        host_wr_ready_o     = 1'b0;
        host_rd_ready_o     = 1'b0;
        start_o             = 1'b0;
        done_o              = 1'b0;
        mat_row_out_ready_o = 1'b0;
        result_out_ready_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                host_wr_ready_o = 1'b1;
                host_rd_ready_o = 1'b1;
                start_o         = w_go_ok;
            end
            ST_LOAD: begin
                host_wr_ready_o = 1'b1;
                start_o         = w_go_ok;
            end
            ST_RUN: begin
                mat_row_out_ready_o = 1'b1;
                result_out_ready_o  = 1'b1;
            end
            ST_DONE: begin
                host_rd_ready_o = 1'b1;
                done_o          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) begin
            r_load_bm <= '0;
            r_res_bm  <= '0;
        end else begin
            if (w_host_wr) r_load_bm[host_wr_addr_i] <= 1'b1;
            r_res_bm <= w_res_bm_next;
        end
    end

    // Banks are deliberately left out of reset so results survive an abort.
    always_ff @(posedge clk_i) begin
        if (w_host_wr)  r_mat[host_wr_addr_i]       <= host_wr_row_i;
        else if (w_wb)  r_mat[mat_row_write_addr_i] <= mat_row_wb_i;
        if (w_res_acc) begin
            r_l[result_addr_i] <= l_col_i;
            r_u[result_addr_i] <= u_row_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mat_row       <= '0;
            r_mat_row_valid <= 1'b0;
            r_mat_rd_addr   <= '0;
        end else begin
            r_mat_row_valid <= mat_row_read_addr_valid_i;
            if (mat_row_read_addr_valid_i) begin
                r_mat_row     <= r_mat[mat_row_read_addr_i];
                r_mat_rd_addr <= mat_row_read_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hrd_data  <= '0;
            r_hrd_valid <= 1'b0;
        end else begin
            r_hrd_valid <= w_host_rd;
            if (w_host_rd) begin
                case (host_rd_sel_i)
                    2'd0:    r_hrd_data <= r_mat[host_rd_addr_i];
                    2'd1:    r_hrd_data <= r_l[host_rd_addr_i];
                    2'd2:    r_hrd_data <= r_u[host_rd_addr_i];
                    default: r_hrd_data <= '0;
                endcase
            end
        end
    end

    assign mat_row_o            = r_mat_row;
    assign mat_row_valid_o      = r_mat_row_valid;
    assign mat_row_read_addr_o  = r_mat_rd_addr;
    assign host_rd_data_o       = r_hrd_data;
    assign host_rd_data_valid_o = r_hrd_valid;
    assign state_o              = r_state;

`ifdef LU_ROWMEM_ERR_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (mat_row_read_addr_valid_i && !r_load_bm[mat_row_read_addr_i])
                    || ((mat_row_wb_valid_i || result_valid_i) && (r_state != ST_RUN))
                    || (host_go_i && !w_load_full);

    always_ff @(posedge clk_i) begin
        if (rst_i || w_clear) r_err <= 1'b0;
        else if (w_err_evt)   r_err <= 1'b1;
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_lu_row_mem.sv
// Directed bench for lu_row_mem: load, start, lu reads/write-backs, results, readback, abort.
module tb_lu_row_mem;
    localparam int SIZE  = 16;
    localparam int WIDTH = 64;
    localparam int AW    = 4;
    localparam int RW    = SIZE * 2 * WIDTH;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          host_wr_valid_i;
    logic          host_wr_ready_o;
    logic [AW-1:0] host_wr_addr_i;
    logic [RW-1:0] host_wr_row_i;
    logic          host_go_i;
    logic          host_rd_valid_i;
    logic          host_rd_ready_o;
    logic [1:0]    host_rd_sel_i;
    logic [AW-1:0] host_rd_addr_i;
    logic          host_rd_data_valid_o;
    logic [RW-1:0] host_rd_data_o;
    logic          start_o;
    logic          done_o;
    logic [AW-1:0] mat_row_read_addr_i;
    logic          mat_row_read_addr_valid_i;
    logic [RW-1:0] mat_row_o;
    logic          mat_row_valid_o;
    logic [AW-1:0] mat_row_read_addr_o;
    logic [RW-1:0] mat_row_wb_i;
    logic          mat_row_wb_valid_i;
    logic [AW-1:0] mat_row_write_addr_i;
    logic          mat_row_out_ready_o;
    logic [RW-1:0] l_col_i;
    logic [RW-1:0] u_row_i;
    logic [AW-1:0] result_addr_i;
    logic          result_valid_i;
    logic          result_out_ready_o;
    logic [1:0]    state_o;
`ifdef LU_ROWMEM_ERR_EN
    logic          err_o;
`endif

    lu_row_mem #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_wr_valid_i(host_wr_valid_i), .host_wr_ready_o(host_wr_ready_o),
        .host_wr_addr_i(host_wr_addr_i), .host_wr_row_i(host_wr_row_i),
        .host_go_i(host_go_i),
        .host_rd_valid_i(host_rd_valid_i), .host_rd_ready_o(host_rd_ready_o),
        .host_rd_sel_i(host_rd_sel_i), .host_rd_addr_i(host_rd_addr_i),
        .host_rd_data_valid_o(host_rd_data_valid_o), .host_rd_data_o(host_rd_data_o),
        .start_o(start_o), .done_o(done_o),
        .mat_row_read_addr_i(mat_row_read_addr_i),
        .mat_row_read_addr_valid_i(mat_row_read_addr_valid_i),
        .mat_row_o(mat_row_o), .mat_row_valid_o(mat_row_valid_o),
        .mat_row_read_addr_o(mat_row_read_addr_o),
        .mat_row_wb_i(mat_row_wb_i), .mat_row_wb_valid_i(mat_row_wb_valid_i),
        .mat_row_write_addr_i(mat_row_write_addr_i),
        .mat_row_out_ready_o(mat_row_out_ready_o),
        .l_col_i(l_col_i), .u_row_i(u_row_i),
        .result_addr_i(result_addr_i), .result_valid_i(result_valid_i),
        .result_out_ready_o(result_out_ready_o),
        .state_o(state_o)
`ifdef LU_ROWMEM_ERR_EN
        , .err_o(err_o)
`endif
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];

    task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [RW-1:0] mk_row(input int i);
        logic [RW-1:0] r;
        r = '0;
        for (int j = 0; j < SIZE; j++) r[j*2*WIDTH +: 2*WIDTH] = {WIDTH'(i), WIDTH'(j)};
        return r;
    endfunction

    // driver tasks
    task automatic host_write(input int a, input logic [RW-1:0] row);
        host_wr_valid_i = 1'b1;
        host_wr_addr_i  = AW'(a);
        host_wr_row_i   = row;
        tick();
        host_wr_valid_i = 1'b0;
    endtask

    task automatic host_read(input string tag, input int sel, input int a, input logic [RW-1:0] exp);
        host_rd_valid_i = 1'b1;
        host_rd_sel_i   = 2'(sel);
        host_rd_addr_i  = AW'(a);
        tick();
        host_rd_valid_i = 1'b0;
        check_val({tag, "_vld"}, RW'(host_rd_data_valid_o), RW'(1'b1));
        check_val(tag, host_rd_data_o, exp);
    endtask

    task automatic send_result(input int a, input int l, input int u);
        result_valid_i = 1'b1;
        result_addr_i  = AW'(a);
        l_col_i        = RW'(l);
        u_row_i        = RW'(u);
        tick();
        result_valid_i = 1'b0;
    endtask

    task automatic load_all;
        for (int i = 0; i < SIZE; i++) host_write(i, mk_row(i));
    endtask

    logic [RW-1:0] aa_row;
    int ord[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    int rd_seq[3] = '{1, 2, 9};

    initial begin
        aa_row = {(RW/8){8'hAA}};
        rst_i = 1'b1;
        host_wr_valid_i = 1'b0; host_wr_addr_i = '0; host_wr_row_i = '0;
        host_go_i = 1'b0;
        host_rd_valid_i = 1'b0; host_rd_sel_i = '0; host_rd_addr_i = '0;
        mat_row_read_addr_i = '0; mat_row_read_addr_valid_i = 1'b0;
        mat_row_wb_i = '0; mat_row_wb_valid_i = 1'b0; mat_row_write_addr_i = '0;
        l_col_i = '0; u_row_i = '0; result_addr_i = '0; result_valid_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;

        check_val("rst_state", RW'(state_o), RW'(2'd0));
        check_val("rst_wr_ready", RW'(host_wr_ready_o), RW'(1'b1));
        check_val("rst_rd_ready", RW'(host_rd_ready_o), RW'(1'b1));
        check_val("rst_done", RW'(done_o), RW'(1'b0));
        check_val("rst_mat_valid", RW'(mat_row_valid_o), RW'(1'b0));
        check_val("rst_hrd_valid", RW'(host_rd_data_valid_o), RW'(1'b0));
        check_val("rst_out_ready", RW'({mat_row_out_ready_o, result_out_ready_o}), RW'(2'b00));
`ifdef LU_ROWMEM_ERR_EN
        check_val("rst_err", RW'(err_o), RW'(1'b0));
`endif

        // load 15 rows, go must be ignored
        for (int i = 0; i < SIZE - 1; i++) host_write(i, mk_row(i));
        check_val("load_state", RW'(state_o), RW'(2'd1));
        host_go_i = 1'b1;
        #1;
        check_val("go15_start", RW'(start_o), RW'(1'b0));
        tick();
        host_go_i = 1'b0;
        check_val("go15_state", RW'(state_o), RW'(2'd1));
`ifdef LU_ROWMEM_ERR_EN
        check_val("go15_err", RW'(err_o), RW'(1'b1));
`endif

        host_write(SIZE - 1, mk_row(SIZE - 1));
        host_go_i = 1'b1;
        #1;
        check_val("go_start", RW'(start_o), RW'(1'b1));
        tick();
        host_go_i = 1'b0;
        check_val("run_state", RW'(state_o), RW'(2'd2));
        check_val("start_pulse", RW'(start_o), RW'(1'b0));
        check_val("run_ready", RW'({mat_row_out_ready_o, result_out_ready_o, host_wr_ready_o}), RW'(3'b110));

        // single lu read
        mat_row_read_addr_valid_i = 1'b1;
        mat_row_read_addr_i = AW'(5);
        tick();
        mat_row_read_addr_valid_i = 1'b0;
        check_val("rd5_valid", RW'(mat_row_valid_o), RW'(1'b1));
        check_val("rd5_addr", RW'(mat_row_read_addr_o), RW'(5));
        check_val("rd5_data", mat_row_o, mk_row(5));
        tick();
        check_val("rd5_valid_drop", RW'(mat_row_valid_o), RW'(1'b0));

        // back-to-back reads, scoreboarded
        mat_row_read_addr_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mat_row_read_addr_i = AW'(rd_seq[k]);
            exp_q.push_back(mk_row(rd_seq[k]));
            tick();
            check_val("b2b_valid", RW'(mat_row_valid_o), RW'(1'b1));
            check_val("b2b_data", mat_row_o, exp_q.pop_front());
        end
        mat_row_read_addr_valid_i = 1'b0;

        // same-cycle read and write of row 3
        mat_row_read_addr_valid_i = 1'b1;
        mat_row_read_addr_i = AW'(3);
        mat_row_wb_valid_i = 1'b1;
        mat_row_write_addr_i = AW'(3);
        mat_row_wb_i = aa_row;
        tick();
        mat_row_wb_valid_i = 1'b0;
        check_val("rw3_old", mat_row_o, mk_row(3));
        tick();
        check_val("rw3_new", mat_row_o, aa_row);

        // successive writes to row 4: last wins
        mat_row_read_addr_valid_i = 1'b0;
        mat_row_wb_valid_i = 1'b1;
        mat_row_write_addr_i = AW'(4);
        mat_row_wb_i = RW'(64'h1111);
        tick();
        mat_row_wb_i = RW'(64'h2222);
        tick();
        mat_row_wb_valid_i = 1'b0;
        mat_row_read_addr_valid_i = 1'b1;
        mat_row_read_addr_i = AW'(4);
        tick();
        mat_row_read_addr_valid_i = 1'b0;
        check_val("wb4_last", mat_row_o, RW'(64'h2222));

        // results, addr 7 twice
        for (int k = 0; k < 17; k++) begin
            if (k == 8) send_result(7, 777, 999);
            else        send_result(ord[k], ord[k] + 100, ord[k] + 200);
            if (k == 15) begin
                check_val("res15_done", RW'(done_o), RW'(1'b0));
                check_val("res15_state", RW'(state_o), RW'(2'd2));
            end
        end
        check_val("res_done", RW'(done_o), RW'(1'b1));
        check_val("res_state", RW'(state_o), RW'(2'd3));
        check_val("done_ready", RW'({mat_row_out_ready_o, result_out_ready_o}), RW'(2'b00));

        // write-back outside RUN is dropped
        mat_row_wb_valid_i = 1'b1;
        mat_row_write_addr_i = AW'(0);
        mat_row_wb_i = aa_row;
        tick();
        mat_row_wb_valid_i = 1'b0;

        host_read("hrd_mat0", 0, 0, mk_row(0));
        host_read("hrd_mat3", 0, 3, aa_row);
        host_read("hrd_l7", 1, 7, RW'(777));
        host_read("hrd_u7", 2, 7, RW'(999));
        host_read("hrd_l2", 1, 2, RW'(102));
        host_read("hrd_u15", 2, 15, RW'(215));
        host_read("hrd_sel3", 3, 7, '0);
        tick();
        check_val("hrd_valid_drop", RW'(host_rd_data_valid_o), RW'(1'b0));

        // DONE -> IDLE clears the load bitmap
        host_go_i = 1'b1;
        tick();
        host_go_i = 1'b0;
        check_val("idle_state", RW'(state_o), RW'(2'd0));
        check_val("idle_done", RW'(done_o), RW'(1'b0));
        host_go_i = 1'b1;
        #1;
        check_val("idle_go_start", RW'(start_o), RW'(1'b0));
        tick();
        host_go_i = 1'b0;
        check_val("idle_go_state", RW'(state_o), RW'(2'd0));

        // abort RUN with a read in flight
        load_all();
        host_go_i = 1'b1;
        tick();
        host_go_i = 1'b0;
        check_val("run2_state", RW'(state_o), RW'(2'd2));
        rst_i = 1'b1;
        mat_row_read_addr_valid_i = 1'b1;
        mat_row_read_addr_i = AW'(6);
        tick();
        rst_i = 1'b0;
        mat_row_read_addr_valid_i = 1'b0;
        check_val("abort_valid", RW'(mat_row_valid_o), RW'(1'b0));
        check_val("abort_state", RW'(state_o), RW'(2'd0));
        host_read("abort_u7", 2, 7, RW'(999));
        host_read("abort_mat6", 0, 6, mk_row(6));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
